adder_share_sched: RTL and testbench
====================================

# adder_share_sched

Round-robin scheduler that shares one instance of the team's 8-bit parallel-prefix `adder` among `NREQ` requesters over valid/ready handshakes. Each accepted beat drives the adder combinationally, and the sum and carry-out are registered into a single-entry response slot. Optionally, a requester can lock the adder across several beats and chain the carry into a wider addition. The block sits between client datapaths and the shared prefix adder.

## Interface
Parameters:
- `NREQ`, default 4: number of requesters (2..8).
- `IDW`, default 3: width of the response ID; must satisfy `2**IDW >= NREQ`.

Ports:
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `req_valid` input NREQ: per-requester beat valid.
- `req_ready` output NREQ: per-requester accept, one-hot or zero.
- `req_a` input NREQ*8: operand A; requester i uses bits [8i+7:8i].
- `req_b` input NREQ*8: operand B, same packing as `req_a`.
- `req_cin` input NREQ: carry-in for the first beat of a transaction.
- `req_last` input NREQ: marks the final beat of a transaction.
- `rsp_valid` output 1: response slot full.
- `rsp_ready` input 1: consumer accepts the response.
- `rsp_id` output IDW: index of the requester that owns the response.
- `rsp_sum` output 8: sum bits.
- `rsp_cout` output 1: carry-out.
- `rsp_last` output 1: copy of `req_last` for the beat.
- `busy` output 1: high when in state LOCK or when `rsp_valid` is high.

## Operation
- States:
  - IDLE: no owner. The round-robin arbiter picks among `req_valid`, starting at the requester after `rr_ptr`.
  - LOCK: `owner` holds the adder.
- Slot-free condition: `slot_free = !rsp_valid || rsp_ready`.
- Grant in IDLE: `req_ready[g] = slot_free && req_valid[g]` for the winner `g` only. All other `req_ready` bits are 0.
- Grant in LOCK: only `owner` may be accepted.
- A beat is accepted when `req_valid[i] && req_ready[i]`. The adder input mux then selects `req_a`/`req_b` of i.
- Carry-in: the first beat uses `req_cin[i]`. Later beats follow the Configuration section.
- On acceptance, the slot loads `sum`, `cout`, `id=i` and `last=req_last[i]`, and `rsp_valid` becomes 1.
- Transitions:
  - IDLE → LOCK: accepted beat with `req_last=0`. Only exists in builds with chaining.
  - LOCK → IDLE: accepted beat with `req_last=1`.
  - IDLE → IDLE: accepted beat with `req_last=1`.
- `rr_ptr` updates to the accepted requester index when a `req_last=1` beat is accepted. It never updates mid-transaction.
- Simultaneous response pop and new accept in the same cycle: the slot reloads, and `rsp_valid` stays 1.
- `rsp_ready=1` while `rsp_valid=0` has no effect.
- While in LOCK with the owner not asserting `req_valid`, the lock holds indefinitely and other requesters are blocked. There is no timeout.

## Timing
- Latency: a beat accepted at edge t drives `rsp_*` valid from edge t to edge t+1, a one-register stage. Throughput is 1 beat per cycle while `rsp_ready=1`.
- `req_ready` is combinational from `req_valid`, `rsp_valid`, `rsp_ready`, the current state and `rr_ptr`. It has no dependency on `req_a`/`req_b`.
- Reset values:
  - `rsp_valid=0`, `rsp_id=0`, `rsp_sum=0`, `rsp_cout=0`, `rsp_last=0`.
  - State IDLE, `rr_ptr=NREQ-1` so that requester 0 has first priority.
  - Stored carry `cy=0`; `busy=0`.
- Reset asserted mid-chain: lock dropped, slot emptied, and the partial transaction discarded. Requesters restart their transactions.
- Response held: while `rsp_valid=1 && rsp_ready=0`, the `rsp_*` outputs stay stable and all `req_ready` bits are 0.

## Configuration
- Macro `ADDER_SHARE_CHAIN_EN` defined:
  - LOCK state is present.
  - On each accept the register `cy` captures `cout`.
  - Beats after the first in a transaction use `cy` as carry-in, and `req_cin` is ignored for those beats.
  - Result: multi-byte carry-propagating addition, least significant byte first.
- Macro undefined:
  - No LOCK state and no `cy` register; every beat is treated as last for arbitration.
  - `req_last` is still copied to `rsp_last`.
  - `req_cin` is used on every beat.
  - `rr_ptr` advances on every accept.

## Structure
- Package `adder_share_pkg`:
  - state enum `{ST_IDLE, ST_LOCK}`.
  - constant `OPW=8`.
  - response struct `{id, sum, cout, last}`.
- Sub-module `rr_arbiter`:
  - parameterised on `NREQ`.
  - inputs: request vector, pointer.
  - outputs: one-hot grant and the encoded index.
- The top level instantiates `rr_arbiter` and one `adder`, plus the mux, FSM and response register.

## Test plan
- Single beat: requester 0 with `a=0x7F`, `b=0x01`, `cin=0`, `last=1` → next cycle `rsp_sum=0x80`, `cout=0`, `id=0`, `busy` returns to 0 once the response is popped.
- Fairness: all 4 requesters hold valid continuously, `rsp_ready=1` → grants follow the order 0,1,2,3,0 on consecutive cycles.
- Chain (macro defined): requester 2 sends beat 1 `a=0xFF`, `b=0x01`, `cin=0`, `last=0`, then beat 2 `a=0x00`, `b=0x00`, `last=1` → responses `0x00/cout=1` then `0x01/cout=0`. Requester 1, valid throughout, is not granted until after beat 2.
- Backpressure: `rsp_ready=0` for 3 cycles with `rsp_valid=1` → all `req_ready` bits are 0 and `rsp_*` stays stable. Releasing `rsp_ready` pops the response and accepts a new beat in the same cycle.
- Reset mid-chain: assert `rst_n=0` in state LOCK → after release the state is IDLE, `rsp_valid=0`, and requester 0 wins first.
- Macro undefined: the chain stimulus with `cin=0` on beat 2 → second response `0x00`, and requester 1 is interleaved between the two beats.

Source files
------------

// File: rtl/adder_share_pkg.sv
// rtl/adder_share_pkg.sv - shared types and constants for the adder-sharing scheduler
package adder_share_pkg;

  localparam int OPW   = 8;
  // Index storage is sized for the largest legal NREQ (8); rsp_id is cast from it.
  localparam int IDX_W = 3;

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_LOCK
  } state_t;

  typedef struct packed {
    logic [IDX_W-1:0] id;
    logic [OPW-1:0]   sum;
    logic             cout;
    logic             last;
  } rsp_t;

endpackage

// File: rtl/adder.sv
// rtl/adder.sv - 8-bit Kogge-Stone parallel-prefix adder with carry-in
module adder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  // Position 0 carries cin as a pure generate so prefix bit i is the carry into a[i].
  logic [4:0][8:0] g;
  logic [3:0][8:0] p;

  always_comb begin
    g = '0;
    p = '0;
    g[0] = {a & b, cin};
    p[0] = {a ^ b, 1'b0};
    for (int l = 0; l < 4; l++) begin
      for (int i = 0; i < 9; i++) begin
        if (i >= (1 << l)) begin
          g[l+1][i] = g[l][i] | (p[l][i] & g[l][i-(1<<l)]);
          if (l < 3) p[l+1][i] = p[l][i] & p[l][i-(1<<l)];
        end else begin
          g[l+1][i] = g[l][i];
          if (l < 3) p[l+1][i] = p[l][i];
        end
      end
    end
  end

  assign sum  = p[0][8:1] ^ g[4][7:0];
  assign cout = g[4][8];

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter; search starts at the requester after ptr
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   idx
);

  logic found;
  int   c;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      c = (int'(ptr) + k) % NREQ;
      if (!found && req[c]) begin
        found  = 1'b1;
        gnt[c] = 1'b1;
        idx    = PW'(c);
      end
    end
  end

endmodule

// File: rtl/adder_share_sched.sv
// rtl/adder_share_sched.sv - round-robin sharing of one prefix adder, registered response slot
// ADDER_SHARE_CHAIN_EN: adds LOCK state and carry chaining across multi-beat transactions.
module adder_share_sched
  import adder_share_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*8-1:0] req_a,
  input  logic [NREQ*8-1:0] req_b,
  input  logic [NREQ-1:0]   req_cin,
  input  logic [NREQ-1:0]   req_last,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [7:0]        rsp_sum,
  output logic              rsp_cout,
  output logic              rsp_last,
  output logic              busy
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   gnt_idx;
  logic [PW-1:0]   owner;
  logic [PW-1:0]   sel;
  logic [NREQ-1:0] gnt;
  logic            in_lock;
  logic            slot_free;
  logic            accept;
  logic            sel_last;
  logic            rr_adv;
  logic [OPW-1:0]  add_a;
  logic [OPW-1:0]  add_b;
  logic [OPW-1:0]  add_sum;
  logic            add_cin;
  logic            add_cout;
  logic            rsp_v;
  rsp_t            rsp_q;

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  assign slot_free = !rsp_v || rsp_ready;

  always_comb begin
    sel       = in_lock ? owner : gnt_idx;
    req_ready = '0;
    if (slot_free) begin
      if (in_lock) req_ready[owner] = req_valid[owner];
      else         req_ready        = gnt;
    end
  end

  assign accept   = |req_ready;
  assign sel_last = req_last[sel];
  assign add_a    = req_a[OPW*sel +: OPW];
  assign add_b    = req_b[OPW*sel +: OPW];

  adder u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

`ifdef ADDER_SHARE_CHAIN_EN
  state_t state;
  state_t state_d;
  logic   cy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      owner <= '0;
      cy    <= 1'b0;
    end else begin
      state <= state_d;
      if (accept) begin
        cy <= add_cout;
        if (!in_lock) owner <= sel;
      end
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: if (accept && !sel_last) state_d = ST_LOCK;
      ST_LOCK: if (accept && sel_last)  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_lock = (state == ST_LOCK);
  assign add_cin = in_lock ? cy : req_cin[sel];
  // The pointer only moves at transaction end so a lock never shifts fairness.
  assign rr_adv  = accept && sel_last;
`else
  assign in_lock = 1'b0;
  assign owner   = gnt_idx;
  assign add_cin = req_cin[sel];
  assign rr_adv  = accept;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_v  <= 1'b0;
      rsp_q  <= '0;
      rr_ptr <= PW'(NREQ - 1);
    end else begin
      if (accept) begin
        rsp_v <= 1'b1;
        rsp_q <= '{id: IDX_W'(sel), sum: add_sum, cout: add_cout, last: sel_last};
      end else if (rsp_ready) begin
        rsp_v <= 1'b0;
      end
      if (rr_adv) rr_ptr <= sel;
    end
  end

  assign rsp_valid = rsp_v;
  assign rsp_id    = IDW'(rsp_q.id);
  assign rsp_sum   = rsp_q.sum;
  assign rsp_cout  = rsp_q.cout;
  assign rsp_last  = rsp_q.last;
  assign busy      = in_lock || rsp_v;

endmodule

// File: tb/tb_adder_share_sched.sv
// tb/tb_adder_share_sched.sv - directed self-checking bench for adder_share_sched
module tb_adder_share_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  req_cin;
  logic [3:0]  req_last;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [2:0]  rsp_id;
  logic [7:0]  rsp_sum;
  logic        rsp_cout;
  logic        rsp_last;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] fa   [4] = '{8'h0F, 8'h1F, 8'h80, 8'hFF};
  logic [7:0] fb   [4] = '{8'h02, 8'h03, 8'h80, 8'h01};
  logic       fc   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [7:0] fsum [4] = '{8'h11, 8'h23, 8'h00, 8'h01};
  logic       fco  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

  always #5 clk = ~clk;

  adder_share_sched #(.NREQ(4), .IDW(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .req_last  (req_last),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_last  (rsp_last),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_beat(input int i, input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input logic last);
    req_a[8*i +: 8] = a;
    req_b[8*i +: 8] = b;
    req_cin[i]      = cin;
    req_last[i]     = last;
  endtask

  task automatic chk_rsp(input string tag, input logic [2:0] id, input logic [7:0] sum,
                         input logic cout, input logic last);
    chk({tag, "_valid"}, rsp_valid, 1);
    chk({tag, "_id"},    rsp_id,    id);
    chk({tag, "_sum"},   rsp_sum,   sum);
    chk({tag, "_cout"},  rsp_cout,  cout);
    chk({tag, "_last"},  rsp_last,  last);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
    req_last  = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    chk("rst_valid", rsp_valid, 0);
    chk("rst_id",    rsp_id,    0);
    chk("rst_sum",   rsp_sum,   0);
    chk("rst_cout",  rsp_cout,  0);
    chk("rst_last",  rsp_last,  0);
    chk("rst_busy",  busy,      0);
    chk("rst_ready", req_ready, 0);
    rst_n = 1'b1;
    tick();

    // single beat
    set_beat(0, 8'h7F, 8'h01, 1'b0, 1'b1);
    req_valid = 4'b0001;
    #1 chk("single_gnt", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    #1 chk_rsp("single", 3'd0, 8'h80, 1'b0, 1'b1);
    chk("single_busy", busy, 1);
    rsp_ready = 1'b1;
    tick();
    #1 chk("single_pop", rsp_valid, 0);
    chk("single_idle", busy, 0);

    // fairness from a fresh reset
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) set_beat(i, fa[i], fb[i], fc[i], 1'b1);
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      #1 chk("fair_gnt", req_ready, 32'(1 << (k % 4)));
      tick();
      #1 chk_rsp("fair", 3'(k % 4), fsum[k % 4], fco[k % 4], 1'b1);
    end

    // backpressure
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      #1 chk("bp_ready", req_ready, 0);
      chk_rsp("bp_hold", 3'd0, 8'h11, 1'b0, 1'b1);
      tick();
    end
    rsp_ready = 1'b1;
    #1 chk("bp_release_gnt", req_ready, 4'b0010);
    tick();
    #1 chk_rsp("bp_reload", 3'd1, 8'h23, 1'b0, 1'b1);

    // two-beat chain from requester 2, requester 1 contending
    set_beat(2, 8'hFF, 8'h01, 1'b0, 1'b0);
    req_valid = 4'b0110;
    #1 chk("chain_b1_gnt", req_ready, 4'b0100);
    tick();
    #1 chk_rsp("chain_b1", 3'd2, 8'h00, 1'b1, 1'b0);
    chk("chain_b1_busy", busy, 1);
    set_beat(2, 8'h00, 8'h00, 1'b0, 1'b1);
`ifdef ADDER_SHARE_CHAIN_EN
    #1 chk("chain_lock_gnt", req_ready, 4'b0100);
    tick();
    #1 chk_rsp("chain_b2", 3'd2, 8'h01, 1'b0, 1'b1);
    req_valid = 4'b0010;
    #1 chk("chain_after_gnt", req_ready, 4'b0010);
    tick();
    #1 chk_rsp("chain_r1", 3'd1, 8'h23, 1'b0, 1'b1);
`else
    #1 chk("nochain_inter_gnt", req_ready, 4'b0010);
    tick();
    #1 chk_rsp("nochain_r1", 3'd1, 8'h23, 1'b0, 1'b1);
    #1 chk("nochain_b2_gnt", req_ready, 4'b0100);
    tick();
    #1 chk_rsp("nochain_b2", 3'd2, 8'h00, 1'b0, 1'b1);
`endif

    // reset while requester 3 is mid-transaction
    set_beat(3, 8'hFF, 8'hFF, 1'b0, 1'b0);
    set_beat(0, 8'h01, 8'h01, 1'b0, 1'b1);
    req_valid = 4'b1001;
    #1 chk("mid_gnt", req_ready, 4'b1000);
    tick();
    #1 chk("mid_busy", busy, 1);
`ifdef ADDER_SHARE_CHAIN_EN
    chk("mid_lock_gnt", req_ready, 4'b1000);
`endif
    rst_n = 1'b0;
    #1 chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_busy", busy, 0);
    rst_n = 1'b1;
    #1 chk("mid_rel_gnt", req_ready, 4'b0001);
    tick();
    #1 chk_rsp("mid_rel", 3'd0, 8'h02, 1'b0, 1'b1);
    req_valid = '0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
